// File: rtl/dsp_div_seq.sv
// Sequential signed divider (radix-2 restoring core on magnitudes, sign fix-up).
// Optional round-to-nearest stage enabled by defining DSP_DIV_ROUND_EN.
module dsp_div_seq #(
    parameter int NBN = 48,
    parameter int NBD = 18
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic signed [NBN-1:0] n,
    input  logic signed [NBD-1:0] d,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [NBN-1:0] q,
    output logic signed [NBD-1:0] r,
    output logic                  div0,
    output logic                  ovf
);

    localparam int CW = $clog2(NBN + 1);
    localparam logic [NBN-1:0] Q_MAX = {1'b0, {(NBN-1){1'b1}}};
    localparam logic [NBN-1:0] Q_MIN = {1'b1, {(NBN-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD, ITER, FIX, ROUND, DONE} state_t;

    state_t         state;
    logic [NBN-1:0] n_reg;
    logic [NBD-1:0] d_reg;
    logic           sign_n;
    logic           sign_q;
    logic [NBN-1:0] num_sh;
    logic [NBN-1:0] quo;
    logic [NBD-1:0] abs_d;
    logic [NBD-1:0] rem;
    logic [CW-1:0]  cnt;
    logic           spec_div0;
    logic           spec_ovf;

    // Magnitudes fit unsigned in the operand width, including |-2^(W-1)| = 2^(W-1).
    logic [NBN-1:0] abs_n_load;
    logic [NBD-1:0] abs_d_load;
    logic           d_is_zero;
    logic           ovf_case;
    logic [NBD:0]   rem_shift;
    logic           ge;
    logic [NBD-1:0] rem_next;
    logic [NBN-1:0] q_trunc;
    logic [NBD-1:0] r_trunc;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        abs_n_load = n_reg[NBN-1] ? -n_reg : n_reg;
        abs_d_load = d_reg[NBD-1] ? -d_reg : d_reg;
        d_is_zero  = (d_reg == '0);
        ovf_case   = (n_reg == Q_MIN) && (d_reg == {NBD{1'b1}});
        rem_shift  = {rem, num_sh[NBN-1]};
        ge         = (rem_shift >= {1'b0, abs_d});
        // When ge holds the true difference is below |d|, so the low bits are exact.
        rem_next   = ge ? (rem_shift[NBD-1:0] - abs_d) : rem_shift[NBD-1:0];
        q_trunc    = sign_q ? -quo : quo;
        r_trunc    = sign_n ? -rem : rem;
    end

`ifdef DSP_DIV_ROUND_EN
    logic [NBN:0]   quo_inc;
    logic           rnd;
    logic           sat;
    logic [NBD-1:0] rem_adj;
    logic [NBN-1:0] q_round;
    logic [NBD-1:0] r_round;
    logic           ovf_round;

    always_comb begin
        rnd       = ({rem, 1'b0} >= {1'b0, abs_d});
        quo_inc   = {1'b0, quo} + (NBN+1)'(1);
        sat       = sign_q ? (quo_inc > {1'b0, Q_MIN}) : (quo_inc > {1'b0, Q_MAX});
        rem_adj   = abs_d - rem;
        q_round   = q_trunc;
        r_round   = r_trunc;
        ovf_round = 1'b0;
        if (rnd && sat) begin
            q_round   = sign_q ? Q_MIN : Q_MAX;
            ovf_round = 1'b1;
        end else if (rnd) begin
            // |r| - |d| is negative, so the remainder flips to the opposite sign of n.
            q_round = sign_q ? -quo_inc[NBN-1:0] : quo_inc[NBN-1:0];
            r_round = sign_n ? rem_adj : -rem_adj;
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q         <= '0;
            r         <= '0;
            div0      <= 1'b0;
            ovf       <= 1'b0;
            n_reg     <= '0;
            d_reg     <= '0;
            sign_n    <= 1'b0;
            sign_q    <= 1'b0;
            num_sh    <= '0;
            quo       <= '0;
            abs_d     <= '0;
            rem       <= '0;
            cnt       <= '0;
            spec_div0 <= 1'b0;
            spec_ovf  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        n_reg    <= n;
                        d_reg    <= d;
                        div0     <= 1'b0;
                        ovf      <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    sign_n    <= n_reg[NBN-1];
                    sign_q    <= n_reg[NBN-1] ^ d_reg[NBD-1];
                    num_sh    <= abs_n_load;
                    abs_d     <= abs_d_load;
                    rem       <= '0;
                    quo       <= '0;
                    cnt       <= CW'(NBN);
                    spec_div0 <= d_is_zero;
                    spec_ovf  <= ovf_case;
                    state     <= (d_is_zero || ovf_case) ? FIX : ITER;
                end
                ITER: begin
                    num_sh <= num_sh << 1;
                    rem    <= rem_next;
                    quo    <= {quo[NBN-2:0], ge};
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= FIX;
                end
                FIX: begin
                    if (spec_div0) begin
                        q    <= sign_n ? Q_MIN : Q_MAX;
                        r    <= '0;
                        div0 <= 1'b1;
                        ovf  <= 1'b0;
                    end else if (spec_ovf) begin
                        q   <= Q_MAX;
                        r   <= '0;
                        ovf <= 1'b1;
                    end else begin
                        q <= q_trunc;
                        r <= r_trunc;
                    end
`ifdef DSP_DIV_ROUND_EN
                    if (spec_div0 || spec_ovf) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        state <= ROUND;
                    end
`else
                    out_valid <= 1'b1;
                    state     <= DONE;
`endif
                end
                ROUND: begin
`ifdef DSP_DIV_ROUND_EN
                    q   <= q_round;
                    r   <= r_round;
                    ovf <= ovf_round;
`endif
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_div_seq.sv
// Self-checking bench for dsp_div_seq: directed corner cases plus randomized
// operands against an arithmetic reference model (honours DSP_DIV_ROUND_EN).
module tb_dsp_div_seq;

    localparam int NBN = 48;
    localparam int NBD = 18;
    localparam longint QMAX = (longint'(1) <<< (NBN - 1)) - 1;
    localparam longint QMIN = -QMAX - 1;
`ifdef DSP_DIV_ROUND_EN
    localparam int LAT = NBN + 3;
`else
    localparam int LAT = NBN + 2;
`endif

    logic                  clock = 1'b0;
    logic                  reset_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic signed [NBN-1:0] n = '0;
    logic signed [NBD-1:0] d = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic signed [NBN-1:0] q;
    logic signed [NBD-1:0] r;
    logic                  div0;
    logic                  ovf;

    int checks = 0;
    int fails  = 0;

    dsp_div_seq #(.NBN(NBN), .NBD(NBD)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n         (n),
        .d         (d),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .div0      (div0),
        .ovf       (ovf)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain signed arithmetic (truncating division) plus the special cases.
    task automatic model(input logic signed [NBN-1:0] nv, input logic signed [NBD-1:0] dv,
                         output logic signed [NBN-1:0] eq, output logic signed [NBD-1:0] er,
                         output logic e0, output logic eo);
        longint nl = nv;
        longint dl = dv;
        longint ql;
        longint rl;
        e0 = 1'b0;
        eo = 1'b0;
        if (dl == 0) begin
            ql = (nl < 0) ? QMIN : QMAX;
            rl = 0;
            e0 = 1'b1;
        end else if (nl == QMIN && dl == -1) begin
            ql = QMAX;
            rl = 0;
            eo = 1'b1;
        end else begin
            ql = nl / dl;
            rl = nl % dl;
`ifdef DSP_DIV_ROUND_EN
            if (2 * ((rl < 0) ? -rl : rl) >= ((dl < 0) ? -dl : dl)) begin
                ql = ql + (((nl < 0) != (dl < 0)) ? -1 : 1);
                rl = nl - ql * dl;
            end
`endif
        end
        eq = ql[NBN-1:0];
        er = rl[NBD-1:0];
    endtask

    task automatic run_op(input logic signed [NBN-1:0] nv, input logic signed [NBD-1:0] dv,
                          input int hold, input string tag);
        logic signed [NBN-1:0] eq;
        logic signed [NBD-1:0] er;
        logic e0, eo;
        int lat;
        int exp_lat;
        model(nv, dv, eq, er, e0, eo);
        exp_lat = (e0 || eo) ? 2 : LAT;
        @(negedge clock);
        check({tag, "_in_ready_idle"}, 64'(in_ready), 64'(1'b1));
        in_valid  = 1'b1;
        n         = nv;
        d         = dv;
        out_ready = (hold == 0);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        n = NBN'({$urandom, $urandom});
        d = NBD'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
            if (lat == 10) begin
                n = NBN'({$urandom, $urandom});
                d = NBD'($urandom);
            end
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_q"}, 64'(q), 64'(eq));
        check({tag, "_r"}, 64'(r), 64'(er));
        check({tag, "_div0"}, 64'(div0), 64'(e0));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clock);
                #1;
                check({tag, "_hold_q"}, 64'(q), 64'(eq));
                check({tag, "_hold_r"}, 64'(r), 64'(er));
                check({tag, "_hold_in_ready"}, 64'(in_ready), 64'(1'b0));
                check({tag, "_hold_out_valid"}, 64'(out_valid), 64'(1'b1));
            end
            @(negedge clock);
            out_ready = 1'b1;
        end
        @(posedge clock);
        #1;
        check({tag, "_release_out_valid"}, 64'(out_valid), 64'(1'b0));
        check({tag, "_release_in_ready"}, 64'(in_ready), 64'(1'b1));
    endtask

    initial begin
        logic signed [NBN-1:0] rn;
        logic signed [NBD-1:0] rd;

        #12;
        check("rst_in_ready", 64'(in_ready), 64'(1'b1));
        check("rst_out_valid", 64'(out_valid), 64'(1'b0));
        check("rst_q", 64'(q), 64'(0));
        check("rst_r", 64'(r), 64'(0));
        check("rst_div0", 64'(div0), 64'(1'b0));
        check("rst_ovf", 64'(ovf), 64'(1'b0));
        @(negedge clock);
        reset_n = 1'b1;

        run_op(NBN'(100), NBD'(7), 0, "pos_pos");
        run_op(-NBN'(100), NBD'(7), 0, "neg_pos");
        run_op(NBN'(100), -NBD'(7), 0, "pos_neg");
        run_op(-NBN'(101), NBD'(2), 0, "half");
        run_op(NBN'(5), NBD'(0), 0, "div0_pos");
        run_op(-NBN'(5), NBD'(0), 0, "div0_neg");
        run_op(NBN'(QMIN), -NBD'(1), 0, "min_m1");
        run_op(NBN'(QMIN), NBD'(1), 0, "min_p1");
        run_op(NBN'(0), NBD'(0), 0, "zero_zero");
        run_op(NBN'(QMAX), NBD'(-(1 <<< (NBD - 1))), 0, "max_dmin");
        run_op(NBN'(12345), NBD'(77), 10, "backpress");
        run_op(-NBN'(999), NBD'(31), 0, "back_to_back");

        for (int i = 0; i < 16; i++) begin
            rn = NBN'({$urandom, $urandom});
            rd = NBD'($urandom);
            if (i % 4 == 1) rd = NBD'($urandom_range(1, 20)) * (($urandom % 2 == 0) ? 1 : -1);
            if (i % 4 == 2) rn = NBN'($urandom_range(0, 5000)) - NBN'(2500);
            run_op(rn, rd, (i % 5 == 3) ? 3 : 0, "rand");
        end

        // Abort a division halfway through the iterations with an asynchronous reset.
        @(negedge clock);
        in_valid = 1'b1;
        n = NBN'(123456789);
        d = NBD'(7);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (1 + NBN / 2) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(1'b0));
        check("midrst_in_ready", 64'(in_ready), 64'(1'b1));
        check("midrst_q", 64'(q), 64'(0));
        check("midrst_r", 64'(r), 64'(0));
        @(negedge clock);
        reset_n = 1'b1;
        run_op(NBN'(1000), NBD'(3), 0, "after_rst");

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
